serdiv_radix: RTL and testbench
===============================

// Module: serdiv_radix
// PURPOSE
//  Parametrised serial integer divider for the execute stage's mult/div unit. Retires BITS_PER_CYCLE quotient
//  bits per cycle and supports RV64 word (*W) ops. Has a CONST_TIME mode in which latency is independent of
//  operand values, closing the divider timing side channel. Same issue/writeback handshake as the existing divider.
// PARAMETERS
//  WIDTH           64  datapath width; power of two, >= 32
//  BITS_PER_CYCLE  1   quotient bits per DIVIDE cycle; 1, 2 or 4; divides 32
//  CONST_TIME      0   1: fixed latency, no alignment/early-out; 0: lzc alignment + early termination
//  TRANS_ID_BITS   3   transaction id width
// PORTS
//  clk_i      in   1              clock
//  rst_i      in   1              reset
//  id_i       in   TRANS_ID_BITS  transaction id of incoming op
//  op_a_i     in   WIDTH          dividend
//  op_b_i     in   WIDTH          divisor
//  opcode_i   in   2              div_op_e: 0 DIVU, 1 DIV, 2 REMU, 3 REM
//  word_i     in   1              1: operate on bits [31:0], sign-extend 32-bit result to WIDTH
//  in_vld_i   in   1              op valid
//  in_rdy_o   out  1              ready to accept op
//  flush_i    in   1              kill in-flight op
//  out_vld_o  out  1              result valid
//  out_rdy_i  in   1              result consumed
//  id_o       out  TRANS_ID_BITS  id of result
//  res_o      out  WIDTH          quotient/remainder
//  Interface: one clock; reset is asynchronous and active-high.
// BEHAVIOUR
//  - Reset: state IDLE, out_vld_o=0, in_rdy_o=0 while rst_i high, id_o=0, res_o=0; all datapath regs cleared.
//  - in_rdy_o = (state==IDLE) & ~flush_i. Op accepted on the edge where in_vld_i & in_rdy_o (= cycle 0).
//  - FSM: IDLE -> DIVIDE on accept; DIVIDE -> FINISH when iteration count hits 0 or early-out;
//    FINISH -> IDLE when out_rdy_i. out_vld_o=1 only in FINISH. res_o/id_o held stable until out_rdy_i.
//  - No accept in FINISH: next op is accepted at the earliest in the cycle after the output handshake.
//  - Operands: effective width E = word_i ? 32 : WIDTH. Signed ops take magnitudes.
//    Quotient truncates toward zero; remainder takes the dividend's sign.
//  - Iterations: CONST_TIME=1: exactly E/BITS_PER_CYCLE DIVIDE cycles for every operand value, incl. b=0 and
//    overflow; out_vld_o first high in cycle E/BITS_PER_CYCLE+1.
//    CONST_TIME=0: shift = lzc(|b|)-lzc(|a|). Iterations = ceil((shift+1)/BITS_PER_CYCLE).
//    Early-out (b==0 or |b|>|a|) takes 1 DIVIDE cycle -> out_vld_o in cycle 2.
//  - Final step of a radix group past the aligned width is masked (no extra quotient bits shifted in).
//  - Special cases (RISC-V): b==0 -> quotient all-ones (E bits, then extended), remainder = a.
//    Signed MIN/-1 -> quotient = MIN, remainder 0.
//    Word mode results always sign-extend bit 31, including DIVUW/REMUW.
//  - Flush: any state -> IDLE next edge; out_vld_o forced 0 in the flush cycle.
//    flush_i with in_vld_i in IDLE: nothing accepted. Flush with out_rdy_i in FINISH: result dropped.
//  - Reset asserted mid-operation: immediate return to reset values; op discarded.
// STRUCTURE
//  - Shared package: div_op_e enum, DIV_MAX_BPC constant. FSM state enum stays local.
//  - Sub-module serdiv_step: one radix-2 compare/conditional-subtract step; inputs rem, divisor, valid mask;
//    outputs next rem and quotient bit. Chain BITS_PER_CYCLE instances combinationally.
//  - lzc from common cells for alignment; generated only when CONST_TIME=0.
//  - Counter width $clog2(WIDTH+1).
// TESTING (WIDTH=64, BITS_PER_CYCLE=2 unless noted)
//  1. DIV a=-20, b=3 -> res_o=-6; REM -> -2; DIVU a=20, b=3 -> 6; REMU -> 2.
//  2. DIVU 100/0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 100/0 -> 100; DIVW 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
//  3. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0.
//     DIVW 0x8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
//  4. DIVUW a=0x1_8000_0000, b=2 -> 0x0000_0000_4000_0000.
//     DIVW a=0x8000_0000, b=2 -> 0xFFFF_FFFF_C000_0000.
//  5. CONST_TIME=1: 7/3, 3/7, x/0 and MIN/-1 all give out_vld_o in cycle 33 (word_i=1: cycle 17).
//     CONST_TIME=0: 3/7 -> cycle 2, res 0.
//  6. Flush in cycle 5 of DIVIDE -> out_vld_o never rises; in_rdy_o=1 next cycle; following 9/2 -> 4.
//     Hold out_rdy_i=0 for 10 cycles -> res_o/id_o stable throughout.

Source files
------------

// File: rtl/serdiv_radix_pkg.sv
// ============================================================================
// serdiv_radix_pkg : shared opcode encoding and limits for the serial divider
// Revision: 1.0
// ============================================================================
`default_nettype none

package serdiv_radix_pkg;

    typedef enum logic [1:0] {
        OP_DIVU = 2'd0,
        OP_DIV  = 2'd1,
        OP_REMU = 2'd2,
        OP_REM  = 2'd3
    } div_op_e;

    localparam int unsigned DIV_MAX_BPC = 4;

endpackage

`default_nettype wire

// File: rtl/serdiv_radix_step.sv
// ============================================================================
// serdiv_step : one radix-2 restoring compare / conditional-subtract step
// Revision: 1.0
// ============================================================================
`default_nettype none

module serdiv_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0]   rem_i,
    input  logic [2*WIDTH-1:0] dvs_i,
    input  logic               vld_i,
    output logic [WIDTH-1:0]   rem_o,
    output logic               q_o
);

    logic w_fits;

    // Divisor is twice as wide so it can start left-aligned without overflow
    assign w_fits = ({{WIDTH{1'b0}}, rem_i} >= dvs_i);
    assign q_o    = vld_i & w_fits;
    assign rem_o  = q_o ? (rem_i - dvs_i[WIDTH-1:0]) : rem_i;

endmodule

`default_nettype wire

// File: rtl/serdiv_radix.sv
// ============================================================================
// serdiv_radix : serial integer divider, BITS_PER_CYCLE quotient bits/cycle,
//                RV64 word ops, optional constant-time operation
// Revision: 1.0
// ============================================================================
`default_nettype none

module serdiv_radix
    import serdiv_radix_pkg::*;
#(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter bit          CONST_TIME     = 1'b0,
    parameter int unsigned TRANS_ID_BITS  = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [TRANS_ID_BITS-1:0] id_i,
    input  logic [WIDTH-1:0]         op_a_i,
    input  logic [WIDTH-1:0]         op_b_i,
    input  logic [1:0]               opcode_i,
    input  logic                     word_i,
    input  logic                     in_vld_i,
    output logic                     in_rdy_o,
    input  logic                     flush_i,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic [TRANS_ID_BITS-1:0] id_o,
    output logic [WIDTH-1:0]         res_o
);

    localparam int unsigned      CW        = $clog2(WIDTH + 1);
    localparam int unsigned      DW        = 2 * WIDTH;
    localparam logic [WIDTH-1:0] WORD_MASK = WIDTH'(32'hFFFF_FFFF);
    localparam logic [CW-1:0]    BPC       = CW'(BITS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [WIDTH-1:0]         rem_q, rem_d;
    logic [WIDTH-1:0]         quo_q, quo_d;
    logic [WIDTH-1:0]         res_q, res_d;
    logic [DW-1:0]            dvs_q, dvs_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     negq_q, negq_d;
    logic                     negr_q, negr_d;
    logic                     remsel_q, remsel_d;
    logic                     word_q, word_d;
    logic [TRANS_ID_BITS-1:0] id_q, id_d;

    // ------------------------------------------------------------------
    // Operand decode: effective width, signs, magnitudes
    // ------------------------------------------------------------------
    div_op_e          w_op;
    logic             w_signed;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_a_x, w_b_x;
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic             w_b_zero;
    logic [CW-1:0]    w_shift;
    logic             w_early;

    assign w_op     = div_op_e'(opcode_i);
    assign w_signed = (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_mask   = word_i ? WORD_MASK : '1;
    assign w_a_x    = op_a_i & w_mask;
    assign w_b_x    = op_b_i & w_mask;
    assign w_a_neg  = w_signed & (word_i ? op_a_i[31] : op_a_i[WIDTH-1]);
    assign w_b_neg  = w_signed & (word_i ? op_b_i[31] : op_b_i[WIDTH-1]);
    assign w_mag_a  = (w_a_neg ? -w_a_x : w_a_x) & w_mask;
    assign w_mag_b  = (w_b_neg ? -w_b_x : w_b_x) & w_mask;
    assign w_b_zero = (w_mag_b == '0);

    generate
        if (!CONST_TIME) begin : g_lzc
            logic [CW-1:0] w_lzc_a, w_lzc_b;

            // Scan upward so the highest set bit determines the count
            always_comb begin
                w_lzc_a = CW'(WIDTH);
                w_lzc_b = CW'(WIDTH);
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if (w_mag_a[i]) w_lzc_a = CW'(int'(WIDTH) - 1 - i);
                    if (w_mag_b[i]) w_lzc_b = CW'(int'(WIDTH) - 1 - i);
                end
            end

            assign w_shift = w_lzc_b - w_lzc_a;
            assign w_early = w_b_zero | (w_mag_b > w_mag_a);
        end else begin : g_const
            assign w_shift = word_i ? CW'(31) : CW'(WIDTH - 1);
            assign w_early = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Combinational chain of radix-2 steps
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]          w_rem_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] w_qbit;
    logic [BITS_PER_CYCLE-1:0] w_step_vld;

    assign w_rem_chain[0] = rem_q;

    generate
        for (genvar j = 0; j < int'(BITS_PER_CYCLE); j++) begin : g_step
            assign w_step_vld[j] = (cnt_q > CW'(j));

            serdiv_step #(
                .WIDTH (WIDTH)
            ) u_step (
                .rem_i (w_rem_chain[j]),
                .dvs_i (dvs_q >> j),
                .vld_i (w_step_vld[j]),
                .rem_o (w_rem_chain[j+1]),
                .q_o   (w_qbit[j])
            );
        end
    endgenerate

    logic [WIDTH-1:0] w_quo_step;
    logic [WIDTH-1:0] w_q_fix, w_r_fix, w_sel, w_res;

    // Masked steps past the aligned width shift nothing into the quotient
    always_comb begin
        w_quo_step = quo_q;
        for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
            if (w_step_vld[j]) w_quo_step = {w_quo_step[WIDTH-2:0], w_qbit[j]};
        end
    end

    assign w_q_fix = negq_q ? -w_quo_step : w_quo_step;
    assign w_r_fix = negr_q ? -w_rem_chain[BITS_PER_CYCLE] : w_rem_chain[BITS_PER_CYCLE];
    assign w_sel   = remsel_q ? w_r_fix : w_q_fix;
    assign w_res   = word_q ? WIDTH'($signed(w_sel[31:0])) : w_sel;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign in_rdy_o  = (state_q == S_IDLE) & ~flush_i & ~rst_i;
    assign out_vld_o = (state_q == S_FINISH) & ~flush_i;
    assign id_o      = id_q;
    assign res_o     = res_q;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        res_d    = res_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        remsel_d = remsel_q;
        word_d   = word_q;
        id_d     = id_q;

        case (state_q)
            S_IDLE: begin
                if (in_vld_i && in_rdy_o) begin
                    state_d  = S_DIVIDE;
                    rem_d    = w_mag_a;
                    dvs_d    = {{WIDTH{1'b0}}, w_mag_b} << w_shift;
                    // Early-out preloads the final quotient and runs no steps
                    quo_d    = (w_early && w_b_zero) ? '1 : '0;
                    cnt_d    = w_early ? '0 : (w_shift + CW'(1));
                    negq_d   = (w_a_neg ^ w_b_neg) & ~w_b_zero;
                    negr_d   = w_a_neg;
                    remsel_d = opcode_i[1];
                    word_d   = word_i;
                    id_d     = id_i;
                end
            end
            S_DIVIDE: begin
                rem_d = w_rem_chain[BITS_PER_CYCLE];
                quo_d = w_quo_step;
                dvs_d = dvs_q >> BITS_PER_CYCLE;
                cnt_d = (cnt_q > BPC) ? (cnt_q - BPC) : '0;
                if (cnt_q <= BPC) begin
                    state_d = S_FINISH;
                    res_d   = w_res;
                end
            end
            S_FINISH: begin
                if (out_rdy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            res_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            remsel_q <= 1'b0;
            word_q   <= 1'b0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            res_q    <= res_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            remsel_q <= remsel_d;
            word_q   <= word_d;
            id_q     <= id_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serdiv_radix.sv
// ============================================================================
// tb_serdiv_radix : directed bench for serdiv_radix (early-out and const-time)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serdiv_radix;
    import serdiv_radix_pkg::*;

    localparam int W   = 64;
    localparam int IDB = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [IDB-1:0] id_in = '0;
    logic [W-1:0]   a = '0, b = '0;
    logic [1:0]     opc = '0;
    logic           word = 1'b0, in_vld = 1'b0, flush = 1'b0, out_rdy = 1'b0;
    logic           rdy0, rdy1, vld0, vld1;
    logic [IDB-1:0] id0, id1;
    logic [W-1:0]   res0, res1;
    int             vectors = 0;
    int             errors  = 0;
    int             nops    = 1;

    always #5 clk = ~clk;

    serdiv_radix #(.WIDTH(W), .BITS_PER_CYCLE(2), .CONST_TIME(1'b0), .TRANS_ID_BITS(IDB)) u_dut (
        .clk_i(clk), .rst_i(rst), .id_i(id_in), .op_a_i(a), .op_b_i(b), .opcode_i(opc),
        .word_i(word), .in_vld_i(in_vld), .in_rdy_o(rdy0), .flush_i(flush),
        .out_vld_o(vld0), .out_rdy_i(out_rdy), .id_o(id0), .res_o(res0));

    serdiv_radix #(.WIDTH(W), .BITS_PER_CYCLE(2), .CONST_TIME(1'b1), .TRANS_ID_BITS(IDB)) u_dut_ct (
        .clk_i(clk), .rst_i(rst), .id_i(id_in), .op_a_i(a), .op_b_i(b), .opcode_i(opc),
        .word_i(word), .in_vld_i(in_vld), .in_rdy_o(rdy1), .flush_i(flush),
        .out_vld_o(vld1), .out_rdy_i(out_rdy), .id_o(id1), .res_o(res1));

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for both dividers idle, then presents one op; returns in cycle 1
    task automatic issue(input string tag, input logic [1:0] op, input logic w,
                         input logic [W-1:0] av, input logic [W-1:0] bv, output logic [IDB-1:0] tid);
        int cyc = 0;
        while (!(rdy0 && rdy1) && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, " idle"}, W'(rdy0 & rdy1), W'(1));
        tid    = IDB'(nops);
        nops++;
        opc    = op;
        word   = w;
        a      = av;
        b      = bv;
        id_in  = tid;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp, input int lat0, input int hold);
        logic [IDB-1:0] tid;
        int lat_a = 0;
        int lat_b = 0;
        int lat1  = w ? 17 : 33;
        int cyc   = 1;
        issue(tag, op, w, av, bv, tid);
        while ((lat_a == 0 || lat_b == 0) && cyc <= 80) begin
            if (vld0 && lat_a == 0) lat_a = cyc;
            if (vld1 && lat_b == 0) lat_b = cyc;
            if (lat_a == 0 || lat_b == 0) begin
                tick();
                cyc++;
            end
        end
        if (lat0 != 0) check({tag, " latency"}, W'(lat_a), W'(lat0));
        check({tag, " ct latency"}, W'(lat_b), W'(lat1));
        check({tag, " res"}, res0, exp);
        check({tag, " ct res"}, res1, exp);
        check({tag, " id"}, W'(id0), W'(tid));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold vld"}, W'(vld0 & vld1), W'(1));
            check({tag, " hold res"}, res0, exp);
            check({tag, " hold ct res"}, res1, exp);
            check({tag, " hold id"}, W'(id0), W'(tid));
        end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        check({tag, " vld drop"}, W'(vld0 | vld1), W'(0));
    endtask

    initial begin
        logic [IDB-1:0] tid;
        logic           seen;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        check("reset rdy", W'(rdy0 | rdy1), W'(0));
        check("reset vld", W'(vld0 | vld1), W'(0));
        check("reset res", res0 | res1, W'(0));
        check("reset id", W'(id0 | id1), W'(0));
        rst = 1'b0;
        #1;
        check("post-reset rdy", W'(rdy0 & rdy1), W'(1));

        // Signed / unsigned basics
        run_op("div -20/3",  2'(OP_DIV),  1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 3, 0);
        run_op("rem -20/3",  2'(OP_REM),  1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 3, 0);
        run_op("divu 20/3",  2'(OP_DIVU), 1'b0, 64'd20, 64'd3, 64'd6, 3, 0);
        run_op("remu 20/3",  2'(OP_REMU), 1'b0, 64'd20, 64'd3, 64'd2, 3, 0);
        run_op("div 7/-3",   2'(OP_DIV),  1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFE, 2, 0);
        run_op("rem 7/-3",   2'(OP_REM),  1'b0, 64'd7, -64'sd3, 64'd1, 2, 0);

        // Divide by zero
        run_op("divu 100/0", 2'(OP_DIVU), 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        run_op("remu 100/0", 2'(OP_REMU), 1'b0, 64'd100, 64'd0, 64'd100, 2, 0);
        run_op("divw 5/0",   2'(OP_DIV),  1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        run_op("remuw ffffffff/0", 2'(OP_REMU), 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 2, 0);

        // Signed overflow
        run_op("div min/-1", 2'(OP_DIV), 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 33, 0);
        run_op("rem min/-1", 2'(OP_REM), 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 33, 0);
        run_op("divw min/-1", 2'(OP_DIV), 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 17, 0);

        // Word-mode extraction and sign extension
        run_op("divuw", 2'(OP_DIVU), 1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 17, 0);
        run_op("divw",  2'(OP_DIV),  1'b1, 64'h0000_0000_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 17, 0);

        // Latency: normal vs early-out
        run_op("divu 7/3", 2'(OP_DIVU), 1'b0, 64'd7, 64'd3, 64'd2, 2, 0);
        run_op("divu 3/7", 2'(OP_DIVU), 1'b0, 64'd3, 64'd7, 64'd0, 2, 0);

        // Flush in cycle 5 of a long divide
        issue("flush div", 2'(OP_DIVU), 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, tid);
        repeat (4) tick();
        flush = 1'b1;
        #1;
        check("flush vld", W'(vld0 | vld1), W'(0));
        check("flush rdy", W'(rdy0 | rdy1), W'(0));
        tick();
        flush = 1'b0;
        #1;
        check("after flush rdy", W'(rdy0 & rdy1), W'(1));
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen = seen | vld0 | vld1;
        end
        check("flushed never valid", W'(seen), W'(0));
        run_op("divu 9/2 hold", 2'(OP_DIVU), 1'b0, 64'd9, 64'd2, 64'd4, 3, 10);

        // Flush with in_vld in IDLE accepts nothing
        a = 64'd50; b = 64'd5; opc = 2'(OP_DIVU); word = 1'b0;
        in_vld = 1'b1;
        flush  = 1'b1;
        tick();
        in_vld = 1'b0;
        flush  = 1'b0;
        #1;
        check("idle flush no accept", W'(rdy0 & rdy1), W'(1));

        // Flush together with out_rdy in FINISH drops the result
        issue("flush finish", 2'(OP_DIVU), 1'b0, 64'd3, 64'd7, tid);
        repeat (32) tick();
        check("finish reached", W'(vld0 & vld1), W'(1));
        flush   = 1'b1;
        out_rdy = 1'b1;
        #1;
        check("finish flush vld", W'(vld0 | vld1), W'(0));
        tick();
        flush   = 1'b0;
        out_rdy = 1'b0;
        #1;
        check("finish flush vld after", W'(vld0 | vld1), W'(0));
        check("finish flush rdy", W'(rdy0 & rdy1), W'(1));

        // Asynchronous reset mid-operation
        issue("reset mid-op", 2'(OP_DIVU), 1'b0, 64'd1000, 64'd3, tid);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("async reset res", res0 | res1, W'(0));
        check("async reset id", W'(id0 | id1), W'(0));
        check("async reset vld", W'(vld0 | vld1), W'(0));
        check("async reset rdy", W'(rdy0 | rdy1), W'(0));
        tick();
        rst = 1'b0;
        #1;
        check("release rdy", W'(rdy0 & rdy1), W'(1));
        run_op("divu 1000/3", 2'(OP_DIVU), 1'b0, 64'd1000, 64'd3, 64'd333, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
